// File: rtl/l1a_readout_if.sv
// l1a_readout_if: first-word-fall-through readout port from the event FIFO to the DAQ
interface l1a_readout_if #(
    parameter int WIDTH = 36
);
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    modport master (output dout, output dout_valid, input dout_ready);
    modport slave (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/l1a_readout.sv
// l1a_readout: captures L1A-windowed frames as header/data/trailer events into a FWFT output FIFO
module l1a_readout #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             valor,
    input  logic             l1a,
    input  logic [3:0]       l1a_window,
    l1a_readout_if.master    rd,
    output logic             busy,
    output logic             l1a_lost,
    output logic [7:0]       lost_cnt,
    output logic [11:0]      l1a_cnt
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, DATA, TRAIL} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp, rp_nx;
    logic [AW:0]      count, count_nx, free;
    logic [3:0]       n_req, left;
    logic [11:0]      e_nx, e_r;
    logic [4:0]       wcnt;
    logic             accept, push, pop;
    logic [WIDTH-1:0] wdata;

    assign n_req    = l1a_window == 4'd0 ? 4'd10 : l1a_window;
    assign e_nx     = l1a_cnt + 12'd1;
    assign free     = (AW+1)'(DEPTH) - count;
    assign accept   = l1a && state == IDLE && free >= (AW+1)'(n_req) + (AW+1)'(2);
    assign pop      = rd.dout_valid && rd.dout_ready;
    assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
    assign rp_nx    = rp + AW'(pop);
    assign busy     = state != IDLE;

    // next state and the single FIFO write per cycle (header, frame or trailer)
    always_comb begin
        state_nx = state;
        push     = 1'b0;
        wdata    = din;
        case (state)
            IDLE: if (accept) begin
                push     = 1'b1;
                wdata    = {4'hA, e_nx, n_req, 15'b0, valor};
                state_nx = valor ? DATA : TRAIL;
            end
            DATA: begin
                push     = 1'b1;
                state_nx = left == 4'd1 ? TRAIL : DATA;
            end
            TRAIL: begin
                push     = 1'b1;
                wdata    = {4'hE, e_r, 4'b0, 16'(wcnt) + 16'd1};
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // event bookkeeping: state, window countdown, event number, words written, L1A counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            left     <= '0;
            e_r      <= '0;
            wcnt     <= '0;
            l1a_lost <= 1'b0;
            lost_cnt <= '0;
            l1a_cnt  <= '0;
        end else begin
            state    <= state_nx;
            left     <= accept ? n_req : state == DATA ? left - 4'd1 : left;
            e_r      <= accept ? e_nx : e_r;
            wcnt     <= accept ? 5'd1 : state == DATA ? wcnt + 5'd1 : wcnt;
            l1a_lost <= l1a && !accept;
            lost_cnt <= l1a && !accept && lost_cnt != 8'hFF ? lost_cnt + 8'd1 : lost_cnt;
            l1a_cnt  <= l1a ? e_nx : l1a_cnt;
        end
    end

    // FIFO storage, written without reset
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

    // pointers plus registered head word; a write landing on the next head slot is bypassed
    always_ff @(posedge clk) begin
        if (rst) begin
            wp            <= '0;
            rp            <= '0;
            count         <= '0;
            rd.dout       <= '0;
            rd.dout_valid <= 1'b0;
        end else begin
            wp            <= wp + AW'(push);
            rp            <= rp_nx;
            count         <= count_nx;
            rd.dout_valid <= count_nx != '0;
            rd.dout       <= count_nx == '0 ? '0 : push && wp == rp_nx ? wdata : mem[rp_nx];
        end
    end
endmodule

// File: doc/l1a_readout.md
# l1a_readout

Consumer end of the L1 pipeline. Takes the delay-aligned 36-bit frames and the window-valid flag produced by the pipeline delay stage. On each accepted L1A, it writes one event into a 64-word output FIFO: a header, the frames in the L1A window, and a trailer. The DAQ side drains the FIFO through a first-word-fall-through valid/ready port.

## Interface
- WIDTH, 36, frame width (header/trailer formats below assume 36)
- DEPTH, 64, output FIFO depth in words (power of two)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- din  in  36  delay-aligned pipeline frame, new frame every clk
- valor  in  1  registered OR of valid bits over the L1A window, aligned to din
- l1a  in  1  level-1 accept, single-cycle pulse
- l1a_window  in  4  window length N in frames; 0 means 10
- dout  out  36  FIFO head word
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer pops head when dout_valid & dout_ready
- busy  out  1  event capture in progress (state != IDLE)
- l1a_lost  out  1  one-cycle pulse when an L1A is dropped
- lost_cnt  out  8  dropped-L1A count, saturates at 255
- l1a_cnt  out  12  L1A number of the most recent l1a, including dropped ones

## Operation
- States: IDLE, DATA, TRAIL.
- Accept condition: l1a=1, state=IDLE, and free = DEPTH - count >= N+2. Count is taken before any same-cycle pop, so the check is conservative.
- Event number: every l1a pulse increments l1a_cnt modulo 4096, whether accepted or not. The event number E is the incremented value.
- On accept, latch N and write the header {4'hA, E[11:0], N[3:0], 15'b0, valor}. N is taken as l1a_window, except 0 is replaced by 10.
  - If valor=1, go to DATA.
  - If valor=0, go to TRAIL (zero suppression: header + trailer only).
- DATA: write din every cycle for exactly N cycles (the first data word is din of the cycle after l1a), then go to TRAIL.
- TRAIL: write {4'hE, E[11:0], 4'b0, 16'(words written including header and trailer)}, then go to IDLE.
- Drop: any l1a that fails the accept condition (busy or insufficient space) does the following:
  - pulses l1a_lost on the next cycle;
  - increments lost_cnt (saturating);
  - writes nothing;
  - leaves the state unchanged.
- FIFO behaviour:
  - Circular, with 6-bit read/write pointers and a 7-bit count.
  - A simultaneous push and pop leaves count unchanged.
  - Overflow cannot occur, because the accept check reserves space.
  - A pop when empty is ignored.
- Reset: state=IDLE, FIFO empty, dout=0, dout_valid=0, busy=0, l1a_lost=0, lost_cnt=0, l1a_cnt=0. A reset mid-event discards the partial event and all queued words; no trailer is written.

## Timing
- Header is written on the l1a edge.
- In the FIFO-empty case, dout_valid rises 1 cycle after l1a and dout shows the header.
- Data word k (k=1..N) is written at edge l1a+k.
- Trailer is written at edge l1a+N+1 (at l1a+1 when suppressed).
- busy is 1 from cycle l1a+1 through the trailer-write cycle. A new l1a is accepted on the first cycle after the trailer write, so the minimum L1A spacing is N+2 cycles (2 when suppressed).
- dout/dout_valid are registered.
  - After a pop, the next word appears the following cycle.
  - With dout_ready held high, throughput is 1 word/cycle.
- Writes into an empty FIFO become visible on dout the cycle after the write.
- l1a_lost, lost_cnt and l1a_cnt update one cycle after the l1a edge.

## Test plan
- Basic event: l1a_window=4, valor=1, din=incrementing 0x100.., dout_ready=1, l1a at t.
  - Expect header A,E=1,N=4,bit0=1, then din(t+1..t+4), then trailer E,cnt=6.
  - busy high t+1..t+5.
- Zero suppression and default window: l1a_window=0, valor=0.
  - Expect header N=10,bit0=0, then trailer cnt=2.
  - Next l1a 2 cycles later is accepted.
- Busy drop: l1a_window=8, second l1a 3 cycles after first.
  - Expect l1a_lost pulse, lost_cnt=1, no event 2 in FIFO.
  - Next accepted event has E=3.
- Backpressure: dout_ready=0, issue 7 events with N=8 (10 words each).
  - Expect 6 stored (60 words) and the 7th dropped.
  - Drain and check exact word order, with no duplicates or holes at pointer wrap.
- Counter limits: 4097 l1a pulses → l1a_cnt wraps to 1; 300 drops → lost_cnt=255.
- Reset mid-event: assert rst during DATA.
  - Expect dout_valid=0, busy=0 and counters 0 on the next cycle.
  - A fresh event is then captured correctly with E=1.
